// File: rtl/prime_factor_checker_if.sv
// Operand/result bundle for prime_factor_checker.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the sender holds valid and its payload until that edge, and
// ready never depends on valid in the same cycle.
interface prime_factor_checker_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic             valid_i;
  logic             ready_i;
  logic [WIDTH-1:0] number;
  logic [TAG_W-1:0] tag_i;
  logic             result;
  logic [WIDTH-1:0] factor;
  logic [TAG_W-1:0] tag_o;
  logic             valid_o;
  logic             ready_o;
  logic             busy;

  // Checker side.
  modport slave (
    input  valid_i, number, tag_i, ready_o,
    output ready_i, result, factor, tag_o, valid_o, busy
  );

  // Producer/consumer side.
  modport master (
    output valid_i, number, tag_i, ready_o,
    input  ready_i, result, factor, tag_o, valid_o, busy
  );
endinterface

// File: rtl/prime_factor_checker.sv
// Trial-division primality checker: reports whether an operand is prime and
// its smallest prime factor. Odd divisors are tried in turn, each remainder
// coming from a restoring shift-subtract divider that runs WIDTH cycles.
module prime_factor_checker #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  prime_factor_checker_if.slave bus,
  output logic [2:0]            o_dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_DIV   = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_n;
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_result;
  logic [WIDTH-1:0] r_factor;

  // Divider step: shift the next dividend bit into the partial remainder and
  // subtract the divisor when it fits. The partial remainder is always < d,
  // so the subtraction result fits in WIDTH bits.
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_rem_step;

  // Next divisor and its square, squared at double width so no WIDTH-bit
  // operand can overflow the comparison.
  logic [WIDTH-1:0]   w_d2;
  logic [2*WIDTH-1:0] w_d2_ext;
  logic [2*WIDTH-1:0] w_sq;
  logic               w_sq_gt;
  logic               w_rem_zero;
  logic               w_trivial;

  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_d});
  assign w_sub      = w_shift[WIDTH-1:0] - r_d;
  assign w_rem_step = w_ge ? w_sub : w_shift[WIDTH-1:0];

  assign w_d2       = r_d + WIDTH'(2);
  assign w_d2_ext   = {{WIDTH{1'b0}}, w_d2};
  assign w_sq       = w_d2_ext * w_d2_ext;
  assign w_sq_gt    = (w_sq > {{WIDTH{1'b0}}, r_n});
  assign w_rem_zero = (r_rem == '0);

  // Anything below 9 or even is decided without division.
  assign w_trivial  = (r_n < WIDTH'(9)) || !r_n[0];

  assign bus.ready_i = (r_state == S_IDLE);
  assign bus.valid_o = (r_state == S_DONE);
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.result  = r_result;
  assign bus.factor  = r_factor;
  assign bus.tag_o   = r_tag;
  assign o_dbg_state = r_state;

  // State register; reset wins over any transfer on the same edge.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.valid_i) w_state_next = S_CHECK;
      S_CHECK: w_state_next = w_trivial ? S_DONE : S_DIV;
      S_DIV:   if (r_cnt == CNT_LAST) w_state_next = S_NEXT;
      S_NEXT:  w_state_next = (w_rem_zero || w_sq_gt) ? S_DONE : S_DIV;
      S_DONE:  if (bus.ready_o) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, divider, divisor walk and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n      <= '0;
      r_tag    <= '0;
      r_d      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_result <= 1'b0;
      r_factor <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.valid_i) begin
            r_n   <= bus.number;
            r_tag <= bus.tag_i;
          end
        end
        S_CHECK: begin
          if (r_n < WIDTH'(2)) begin
            r_result <= 1'b0;
            r_factor <= '0;
          end else if (r_n < WIDTH'(4)) begin
            r_result <= 1'b1;
            r_factor <= r_n;
          end else if (!r_n[0]) begin
            r_result <= 1'b0;
            r_factor <= WIDTH'(2);
          end else if (r_n < WIDTH'(9)) begin
            r_result <= 1'b1;
            r_factor <= r_n;
          end else begin
            r_d   <= WIDTH'(3);
            r_rem <= '0;
            r_quo <= r_n;
            r_cnt <= '0;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_step;
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_NEXT: begin
          if (w_rem_zero) begin
            r_result <= 1'b0;
            r_factor <= r_d;
          end else begin
            r_d <= w_d2;
            if (w_sq_gt) begin
              r_result <= 1'b1;
              r_factor <= r_n;
            end else begin
              r_rem <= '0;
              r_quo <= r_n;
              r_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_factor_checker.sv
// Directed bench for prime_factor_checker: hand-computed smallest factors
// and latencies, backpressure hold, and reset in the middle of a division.
module tb_prime_factor_checker;

  localparam int WIDTH = 16;
  localparam int TAG_W = 4;
  localparam int LAT_BUDGET = 3000;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         n_vec;
  int         n_err;

  prime_factor_checker_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  prime_factor_checker #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One operation: accept, measure edges to the first edge that sees valid_o,
  // check payload, hold ready_o low for 'hold' cycles while poking valid_i,
  // then release and check the return to idle.
  task automatic do_op(input logic [WIDTH-1:0] n, input logic [TAG_W-1:0] tag,
                       input logic exp_res, input logic [WIDTH-1:0] exp_fac,
                       input int exp_lat, input int hold);
    int   lat;
    int   w;
    logic got;
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.number  = n;
    bus.tag_i   = tag;
    w = 0;
    while (!bus.ready_i && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (lat < LAT_BUDGET && !got) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
      lat++;
      got = bus.valid_o;
    end
    check($sformatf("n=%0d valid_o", n), {31'd0, got}, 32'd1);
    check($sformatf("n=%0d latency", n), lat, exp_lat);
    check($sformatf("n=%0d result", n), {31'd0, bus.result}, {31'd0, exp_res});
    check($sformatf("n=%0d factor", n), {16'd0, bus.factor}, {16'd0, exp_fac});
    check($sformatf("n=%0d tag_o", n), {28'd0, bus.tag_o}, {28'd0, tag});
    for (int i = 0; i < hold; i++) begin
      bus.valid_i = 1'b1;
      bus.number  = 16'd1234;
      bus.tag_i   = ~tag;
      @(negedge clk);
      check($sformatf("n=%0d hold valid_o", n), {31'd0, bus.valid_o}, 32'd1);
      check($sformatf("n=%0d hold ready_i", n), {31'd0, bus.ready_i}, 32'd0);
      check($sformatf("n=%0d hold factor", n), {16'd0, bus.factor}, {16'd0, exp_fac});
      check($sformatf("n=%0d hold result", n), {31'd0, bus.result}, {31'd0, exp_res});
      check($sformatf("n=%0d hold tag_o", n), {28'd0, bus.tag_o}, {28'd0, tag});
    end
    bus.valid_i = 1'b0;
    bus.ready_o = 1'b1;
    @(negedge clk);
    bus.ready_o = 1'b0;
    check($sformatf("n=%0d post valid_o", n), {31'd0, bus.valid_o}, 32'd0);
    check($sformatf("n=%0d post ready_i", n), {31'd0, bus.ready_i}, 32'd1);
    check($sformatf("n=%0d post busy", n), {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " ready_i"}, {31'd0, bus.ready_i}, 32'd1);
    check({tag, " valid_o"}, {31'd0, bus.valid_o}, 32'd0);
    check({tag, " busy"},    {31'd0, bus.busy},    32'd0);
    check({tag, " result"},  {31'd0, bus.result},  32'd0);
    check({tag, " factor"},  {16'd0, bus.factor},  32'd0);
    check({tag, " tag_o"},   {28'd0, bus.tag_o},   32'd0);
    check({tag, " state"},   {29'd0, dbg_state},   32'd0);
  endtask

  initial begin
    logic saw_valid;
    n_vec = 0;
    n_err = 0;
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.number  = '0;
    bus.tag_i   = '0;
    bus.ready_o = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Trivial operands: decided in CHECK, latency 2.
    do_op(16'd0, 4'd1, 1'b0, 16'd0, 2, 0);
    do_op(16'd1, 4'd2, 1'b0, 16'd0, 2, 0);
    do_op(16'd2, 4'd3, 1'b1, 16'd2, 2, 0);
    do_op(16'd4, 4'd4, 1'b0, 16'd2, 2, 0);
    do_op(16'd3, 4'd6, 1'b1, 16'd3, 2, 0);
    do_op(16'd7, 4'd7, 1'b1, 16'd7, 2, 0);

    // Trial division: latency 2 + k*17.
    do_op(16'd9,   4'd5,  1'b0, 16'd3,  19, 0);  // k=1
    do_op(16'd97,  4'd8,  1'b1, 16'd97, 70, 0);  // d=3,5,7,9
    do_op(16'd11,  4'd9,  1'b1, 16'd11, 19, 0);  // 5*5 > 11 after d=3
    do_op(16'd15,  4'd10, 1'b0, 16'd3,  19, 0);
    do_op(16'd49,  4'd11, 1'b0, 16'd7,  53, 0);  // d=3,5,7
    do_op(16'd121, 4'd12, 1'b0, 16'd11, 87, 0);  // d=3..11

    // Backpressure: ready_o held low for 10 cycles, new valid_i ignored.
    do_op(16'd25, 4'd13, 1'b0, 16'd5, 36, 10);   // d=3,5
    do_op(16'd5,  4'd14, 1'b1, 16'd5, 2, 0);     // shows 1234 was not captured

    // WIDTH-16 extremes.
    do_op(16'd65521, 4'd15, 1'b1, 16'd65521, 2161, 0); // d=3..255, 127 tries
    do_op(16'd65535, 4'd1,  1'b0, 16'd3,     19,   0);
    do_op(16'd65531, 4'd2,  1'b0, 16'd19,    155,  0); // 19*3449, d=3..19
    do_op(16'd65533, 4'd3,  1'b0, 16'd13,    104,  0); // 13*5041, d=3..13

    // Reset while dividing 97.
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.number  = 16'd97;
    bus.tag_i   = 4'd6;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (5) @(negedge clk);
    check("mid-op state", {29'd0, dbg_state}, 32'd2);
    bus.ready_o = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("mid-op reset");
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      saw_valid = saw_valid | bus.valid_o;
    end
    check("aborted result", {31'd0, saw_valid}, 32'd0);
    bus.ready_o = 1'b0;
    do_op(16'd7, 4'd9, 1'b1, 16'd7, 2, 0);

    // Reset beats an input transfer on the same edge.
    @(negedge clk);
    rst         = 1'b1;
    bus.valid_i = 1'b1;
    bus.number  = 16'd9;
    @(negedge clk);
    rst         = 1'b0;
    bus.valid_i = 1'b0;
    check("rst vs accept busy", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("rst vs accept idle", {29'd0, dbg_state}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
